// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: filters the keyboard clock, deframes 11-bit frames
// and presents make codes as tasta with a stretched done strobe.
module ps2_key_receiver #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 10000,
   parameter int DONE_HOLD  = 800
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] tasta,
   output logic       done,
   output logic       parity_err
);

   localparam int FC_W = $clog2(FILTER_LEN + 1);
   localparam int TO_W = $clog2(TIMEOUT + 1);
   localparam int HD_W = $clog2(DONE_HOLD + 1);
   localparam logic [FC_W-1:0] FILT_MAX = FC_W'(FILTER_LEN - 1);
   localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT - 1);
   localparam logic [HD_W-1:0] HOLD_MAX = HD_W'(DONE_HOLD - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t            state_q, state_d;
   logic              pck_s1_q, pck_s1_d, pck_s2_q, pck_s2_d;
   logic              pdt_s1_q, pdt_s1_d, pdt_s2_q, pdt_s2_d;
   logic              fclk_q, fclk_d, fclk_prev_q, fclk_prev_d;
   logic [FC_W-1:0]   filt_cnt_q, filt_cnt_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        shift_q, shift_d;
   logic              par_q, par_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic              brk_q, brk_d;
   logic [HD_W-1:0]   hold_q, hold_d;
   logic [7:0]        tasta_q, tasta_d;
   logic              done_q, done_d;
   logic              perr_q, perr_d;
   logic              edge_n;
   logic              timeout;
   logic              frame_ok;

   always_comb begin
      pck_s1_d    = ps2_clk;
      pck_s2_d    = pck_s1_q;
      pdt_s1_d    = ps2_data;
      pdt_s2_d    = pdt_s1_q;
      fclk_d      = fclk_q;
      fclk_prev_d = fclk_q;
      filt_cnt_d  = '0;
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      par_d       = par_q;
      to_cnt_d    = to_cnt_q;
      brk_d       = brk_q;
      hold_d      = hold_q;
      tasta_d     = tasta_q;
      done_d      = done_q;
      perr_d      = 1'b0;
      timeout     = 1'b0;
      edge_n      = fclk_prev_q & ~fclk_q;
      frame_ok    = pdt_s2_q & (^{shift_q, par_q});

      // Level changes only after FILTER_LEN consecutive disagreeing samples
      if (pck_s2_q != fclk_q) begin
         if (filt_cnt_q == FILT_MAX) begin
            fclk_d = ~fclk_q;
         end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
         end
      end

      if (hold_q != '0) begin
         hold_d = hold_q - 1'b1;
      end else begin
         done_d = 1'b0;
      end

      if (state_q == IDLE || edge_n) begin
         to_cnt_d = '0;
      end else if (to_cnt_q == TO_MAX) begin
         to_cnt_d = '0;
         timeout  = 1'b1;
      end else begin
         to_cnt_d = to_cnt_q + 1'b1;
      end

      if (edge_n) begin
         unique case (state_q)
            IDLE: begin
               if (!pdt_s2_q) begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
                  shift_d   = '0;
               end
            end
            DATA: begin
               shift_d   = {pdt_s2_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: begin
               par_d   = pdt_s2_q;
               state_d = STOP;
            end
            STOP: begin
               state_d = IDLE;
               if (!frame_ok) begin
                  perr_d = 1'b1;
               end else begin
                  priority case (1'b1)
                     (shift_q == 8'hF0): brk_d = 1'b1;
                     (shift_q == 8'hE0): brk_d = brk_q;
                     brk_q:              brk_d = 1'b0;
                     default: begin
                        tasta_d = shift_q;
                        done_d  = 1'b1;
                        hold_d  = HOLD_MAX;
                     end
                  endcase
               end
            end
         endcase
      end

      if (timeout) state_d = IDLE;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         pck_s1_q    <= 1'b1;
         pck_s2_q    <= 1'b1;
         pdt_s1_q    <= 1'b1;
         pdt_s2_q    <= 1'b1;
         fclk_q      <= 1'b1;
         fclk_prev_q <= 1'b1;
         filt_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         par_q       <= 1'b0;
         to_cnt_q    <= '0;
         brk_q       <= 1'b0;
         hold_q      <= '0;
         tasta_q     <= '0;
         done_q      <= 1'b0;
         perr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pck_s1_q    <= pck_s1_d;
         pck_s2_q    <= pck_s2_d;
         pdt_s1_q    <= pdt_s1_d;
         pdt_s2_q    <= pdt_s2_d;
         fclk_q      <= fclk_d;
         fclk_prev_q <= fclk_prev_d;
         filt_cnt_q  <= filt_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         par_q       <= par_d;
         to_cnt_q    <= to_cnt_d;
         brk_q       <= brk_d;
         hold_q      <= hold_d;
         tasta_q     <= tasta_d;
         done_q      <= done_d;
         perr_q      <= perr_d;
      end
   end

   assign tasta      = tasta_q;
   assign done       = done_q;
   assign parity_err = perr_q;

endmodule

// File: doc/ps2_key_receiver.md
Name: ps2_key_receiver

Overview:
- Upstream stage of the Pong game FSM: receives PS/2 keyboard frames and produces the scan-code byte `tasta` and the `done` strobe that the FSM latches as `key_pressed`.
- Decodes make codes only. Break sequences (F0 xx) are swallowed. The E0 prefix is stripped.
- Holds `done` long enough to overlap the FSM's active-zone sampling window.

Parameters:
- FILTER_LEN, 8: consecutive identical samples required before the filtered ps2_clk changes level.
- TIMEOUT, 10000: clocks without a filtered ps2_clk falling edge, while mid-frame, before the frame is aborted.
- DONE_HOLD, 800: clocks `done` stays high after a make code (at least one VGA line).

Ports:
- clock, in, 1: system clock.
- reset, in, 1: asynchronous active-low reset.
- ps2_clk, in, 1: raw PS/2 clock from the keyboard, asynchronous.
- ps2_data, in, 1: raw PS/2 data, asynchronous.
- tasta, out, 8: last decoded make code.
- done, out, 1: high while `tasta` holds a freshly decoded make code.
- parity_err, out, 1: one-clock pulse on parity or stop-bit error.

Behaviour:
- Reset: one clock domain, `clock`; reset is asynchronous and active-low (`reset`).
  - Reset values: tasta=0, done=0, parity_err=0, FSM=IDLE.
  - Also cleared: bit counter, shift register, hold counter, timeout counter, break flag, filter state (filtered clk=1).
  - Reset mid-frame discards the partial frame.
- Input path: ps2_clk and ps2_data each pass through a 2-FF synchronizer.
  - Filtered clk toggles only after FILTER_LEN consecutive synchronized samples differ from its current value.
  - Data is sampled on the clock in which a filtered falling edge is detected (edge_n cycle).
- FSM (advances only on edge_n except for the timeout):
  - IDLE: data=0 (start bit) -> DATA with bit_cnt=0. data=1 -> stay in IDLE; no error flag.
  - DATA: shift data in LSB first; bit_cnt++. After the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: always return to IDLE.
    - Frame is valid iff data=1 (stop bit) and the XOR of the 8 data bits and the parity bit = 1 (odd parity).
    - Invalid frame -> parity_err=1 for exactly one clock (the clock after edge_n); byte discarded; break flag unchanged.
- Timeout:
  - In DATA, PARITY or STOP, the timeout counter increments every clock and clears on each edge_n.
  - On reaching TIMEOUT: FSM -> IDLE, partial byte discarded, no parity_err.
  - The counter is held at 0 in IDLE.
- Byte handling (valid frame, byte B):
  - B=0xF0: set break flag; no output.
  - B=0xE0: ignored; no output; break flag unchanged.
  - Break flag set: clear it; no output (key release).
  - Otherwise (make code):
    - tasta<=B and done<=1 on the clock after the stop-bit edge_n.
    - Hold counter loads DONE_HOLD; done falls when it expires, i.e. done is high for exactly DONE_HOLD clocks.
- Latency: done rises FILTER_LEN+3 clocks (±1) after the raw ps2_clk falling edge of the stop bit.
- New make code while done is high: tasta updates, hold counter reloads, done stays high with no low gap.
  - Typematic repeats therefore produce repeated updates; each one reloads the hold.
- tasta holds its last value after done falls.
- Host-to-device (inhibit, command) is not supported. The block never drives ps2_clk or ps2_data.

Test Plan:
- Glitch filter / edges: one clean frame for 0x1C (A), 40 us bit period.
  - Expect tasta=0x1C and done=1 for exactly 800 clocks, then done=0.
  - Expect parity_err never asserted.
- Break sequence: frames 0x23, 0xF0, 0x23 (D press, then release).
  - Expect exactly one done assertion with tasta=0x23.
  - The release causes no done rise and no hold reload.
- Parity error: frame 0x29 with the parity bit inverted.
  - Expect a single one-clock parity_err pulse, no done, tasta unchanged.
  - A following good 0x29 frame decodes normally.
- E0 prefix and timeout:
  - Frames E0 then 0x75: expect tasta=0x75 with done.
  - Then stop ps2_clk after 4 data bits for more than 10000 clocks, followed by a good 0x16 frame: expect tasta=0x16; the partial frame produces no output.
- Glitch and back-to-back:
  - Inject 3-clock low glitches on ps2_clk mid-frame: expect them ignored and the byte decoded correctly.
  - Send 0x4B then 0x3B within 800 clocks: expect done to stay continuously high and tasta to go 0x4B->0x3B.
- Reset mid-frame: assert reset after 5 data bits, release, then send 0x1E.
  - Expect all outputs to be 0 during reset.
  - Expect tasta=0x1E with done afterwards, with no stray output from the aborted frame.
